rr_arbiter_n: RTL and testbench

//  Parametrised N-way round-robin bus arbiter with grant lock; successor to the fixed 4-way arbiter.

---
 rtl/rra_pkg.sv | 34 +++
 rtl/rra_rr_pick.sv | 41 ++++
 rtl/rr_arbiter_n.sv | 135 +++++++++++++
 tb/tb_rr_arbiter_n.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rra_pkg.sv
// rra_pkg -- shared helpers for the N-way round-robin arbiter.
//
// Contents:
//   RRA_MAX_N / RRA_MAX_IDXW : upper bound on requesters supported by the
//                              one-hot decoder below (64 masters, 6-bit index)
//   rra_width()              : clog2-based width helper, never returns 0
//   onehot_to_idx()          : one-hot vector -> binary index (0 for all-zero)
//
// Configuration macro used by the arbiter: RRA_TIMEOUT_EN.
package rra_pkg;

    localparam int RRA_MAX_N    = 64;
    localparam int RRA_MAX_IDXW = 6;

    // Width needed to hold values 0..n-1; at least one bit so that
    // degenerate configurations still produce legal vectors.
    function automatic int rra_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // OR-reduction encoder: valid only for one-hot (or zero) input, which
    // the arbiter guarantees for every vector it decodes.
    function automatic logic [RRA_MAX_IDXW-1:0] onehot_to_idx(input logic [RRA_MAX_N-1:0] oh);
        logic [RRA_MAX_IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < RRA_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | RRA_MAX_IDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rra_rr_pick.sv
// rra_rr_pick -- combinational rotate-priority picker.
//
// Searches req_i starting at ptr_i+1, ptr_i+2, ... wrapping modulo N and
// returns the first set bit as a one-hot vector.
//
// Ports:
//   req_i    in  N     candidate requests
//   ptr_i    in  IDXW  last winner; highest priority goes to ptr_i+1
//   onehot_o out N     one-hot winner (all-zero when nothing requested)
//   found_o  out 1     at least one request present
module rra_rr_pick
    import rra_pkg::*;
#(
    parameter int N = 4,
    localparam int IDXW = rra_width(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    onehot_o,
    output logic            found_o
);

    logic [IDXW-1:0] start;
    logic [2*N-1:0]  dbl_req;
    logic [N-1:0]    rotated;
    logic [N-1:0]    rot_oh;

    // Rotate so the search start lands on bit 0, take the lowest set bit,
    // then rotate back. When ptr_i = N-1 the increment either wraps to 0
    // (N a power of two) or equals N, and a shift by N of the doubled
    // vector is again an identity rotation, so both cases start at master 0.
    always_comb begin
        start    = ptr_i + IDXW'(1);
        dbl_req  = {req_i, req_i};
        rotated  = N'(dbl_req >> start);
        rot_oh   = rotated & (~rotated + N'(1));
        onehot_o = N'(({rot_oh, rot_oh} << start) >> N);
        found_o  = |req_i;
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n -- N-way round-robin bus arbiter with grant lock.
//
// The current holder keeps the bus while its request stays high; otherwise
// the next requester after the last winner (ptr) is granted. All outputs are
// registered; gnt_idx can drive the shared-bus mux select directly.
//
// Optional feature (macro RRA_TIMEOUT_EN): a hold counter forces rotation
// after MAX_HOLD consecutive grant cycles when another master is waiting.
//
// Ports:
//   clk         in  1     clock, rising edge
//   rst_n       in  1     asynchronous reset, active low
//   req         in  N     request per master
//   gnt         out N     one-hot grant, zero when idle
//   gnt_idx     out IDXW  index of granted master, 0 when idle
//   gnt_vld     out 1     grant present
//   gnt_new     out 1     pulse: grant changed to a new non-zero value
//   timeout_evt out 1     pulse: grant revoked by hold timeout
module rr_arbiter_n
    import rra_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDXW    = rra_width(N),
    localparam int CNTW    = rra_width(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            gnt_new,
    output logic            timeout_evt
);

    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic            gnt_new_q, gnt_new_d;

    logic            busy;
    logic            expire;
    logic [N-1:0]    pick_req;
    logic [N-1:0]    pick_oh;
    logic            pick_found;

    assign busy = |(req & gnt_q);

`ifdef RRA_TIMEOUT_EN
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;
    logic            timeout_q;

    // A saturated counter still counts as expired, so a holder that has
    // kept the bus alone rotates away as soon as a competitor shows up.
    assign expire = busy && (hold_cnt_q >= CNTW'(MAX_HOLD - 1)) && (|(req & ~gnt_q));

    // ptr already equals the holder, so masking the holder out makes the
    // picker choose the next requester after it.
    assign pick_req = expire ? (req & ~gnt_q) : req;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (gnt_d != gnt_q) begin
            hold_cnt_d = '0;
        end else if ((|gnt_q) && (hold_cnt_q != CNTW'(MAX_HOLD))) begin
            hold_cnt_d = hold_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= expire;
        end
    end

    assign timeout_evt = timeout_q;
`else
    logic [CNTW-1:0] unused_hold_cfg;

    assign unused_hold_cfg = CNTW'(MAX_HOLD);
    assign expire          = 1'b0;
    assign pick_req        = req;
    assign timeout_evt     = 1'b0;
`endif

    rra_rr_pick #(
        .N (N)
    ) u_pick (
        .req_i    (pick_req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .found_o  (pick_found)
    );

    always_comb begin
        gnt_d = gnt_q;
        if (!busy || expire) begin
            gnt_d = pick_found ? pick_oh : '0;
        end
        gnt_idx_d = IDXW'(onehot_to_idx(RRA_MAX_N'(gnt_d)));
        gnt_vld_d = |gnt_d;
        gnt_new_d = (|gnt_d) && (gnt_d != gnt_q);
        // While holding, gnt_idx_d already equals ptr_q; on idle ptr keeps
        // the last winner so rotation resumes after it.
        ptr_d     = (|gnt_d) ? gnt_idx_d : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            ptr_q     <= IDXW'(N - 1);
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            gnt_new_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_new_q <= gnt_new_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_new = gnt_new_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n -- bench for rr_arbiter_n with a 4-way and an 8-way
// instance driven side by side. A behavioural model (owner / last winner /
// hold length as integers) predicts every output after every clock edge.
// Timeout expectations follow RRA_TIMEOUT_EN if the bench is built with it.
module tb_rr_arbiter_n;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req4;
    logic [7:0] req8;
    logic [3:0] gnt4;
    logic [1:0] idx4;
    logic       vld4, new4, to4;
    logic [7:0] gnt8;
    logic [2:0] idx8;
    logic       vld8, new8, to8;

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(4), .MAX_HOLD(MH)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4), .gnt_idx(idx4),
        .gnt_vld(vld4), .gnt_new(new4), .timeout_evt(to4)
    );

    rr_arbiter_n #(.N(8), .MAX_HOLD(MH)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .gnt_idx(idx8),
        .gnt_vld(vld8), .gnt_new(new8), .timeout_evt(to8)
    );

    int checks = 0;
    int errors = 0;

    // model state per instance: u=0 -> N=4, u=1 -> N=8
    int m_owner[2];
    int m_last[2];
    int m_hold[2];
    bit m_new[2];
    bit m_to[2];

    function automatic int nn(input int u);
        return (u == 0) ? 4 : 8;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1;
            m_last[u]  = nn(u) - 1;
            m_hold[u]  = 0;
            m_new[u]   = 1'b0;
            m_to[u]    = 1'b0;
        end
    endtask

    // One arbitration decision from the rules: keep the holder while it
    // requests (unless its hold time ran out and someone else waits),
    // otherwise scan forward from the last winner.
    task automatic model_step(input int u, input logic [7:0] r);
        int n;
        int own;
        int nxt;
        int c;
        bit others;
        bit to;
        n      = nn(u);
        own    = m_owner[u];
        others = 1'b0;
        to     = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (r[i] && i != own) others = 1'b1;
        end
`ifdef RRA_TIMEOUT_EN
        if (own >= 0 && r[own] && m_hold[u] >= MH - 1 && others) to = 1'b1;
`endif
        nxt = own;
        if (own < 0 || !r[own] || to) begin
            nxt = -1;
            for (int k = 1; k <= n; k++) begin
                c = (m_last[u] + k) % n;
                if (nxt < 0 && r[c] && !(to && c == own)) nxt = c;
            end
        end
        m_new[u] = (nxt >= 0) && (nxt != own);
        m_to[u]  = to;
        if (nxt != own) m_hold[u] = 0;
        else if (nxt >= 0 && m_hold[u] < MH) m_hold[u] = m_hold[u] + 1;
        if (nxt >= 0) m_last[u] = nxt;
        m_owner[u] = nxt;
    endtask

    task automatic check_outputs(input string tag);
        for (int u = 0; u < 2; u++) begin
            logic [7:0] og, eg;
            int oi, ei;
            logic ov, on, ot;
            if (u == 0) begin
                og = {4'b0, gnt4}; oi = int'(idx4); ov = vld4; on = new4; ot = to4;
            end else begin
                og = gnt8; oi = int'(idx8); ov = vld8; on = new8; ot = to8;
            end
            eg = (m_owner[u] >= 0) ? (8'd1 << m_owner[u]) : 8'd0;
            ei = (m_owner[u] >= 0) ? m_owner[u] : 0;
            checks++;
            if (og !== eg) begin
                errors++;
                $display("FAIL %s n=%0d gnt: got %h expected %h", tag, nn(u), og, eg);
            end
            checks++;
            if (oi != ei) begin
                errors++;
                $display("FAIL %s n=%0d gnt_idx: got %0d expected %0d", tag, nn(u), oi, ei);
            end
            checks++;
            if (ov !== (m_owner[u] >= 0)) begin
                errors++;
                $display("FAIL %s n=%0d gnt_vld: got %b expected %b", tag, nn(u), ov, m_owner[u] >= 0);
            end
            checks++;
            if (on !== m_new[u]) begin
                errors++;
                $display("FAIL %s n=%0d gnt_new: got %b expected %b", tag, nn(u), on, m_new[u]);
            end
            checks++;
            if (ot !== m_to[u]) begin
                errors++;
                $display("FAIL %s n=%0d timeout_evt: got %b expected %b", tag, nn(u), ot, m_to[u]);
            end
            checks++;
            if ($countones(og) > 1) begin
                errors++;
                $display("FAIL %s n=%0d onehot: got %h expected at most one bit", tag, nn(u), og);
            end
        end
    endtask

    // Drive both instances for one cycle, then compare after the edge.
    task automatic step(input logic [3:0] r4, input logic [7:0] r8, input string tag);
        req4 = r4;
        req8 = r8;
        model_step(0, {4'b0, r4});
        model_step(1, r8);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req4  = '0;
        req8  = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        check_outputs("reset");
    endtask

    task automatic test_reset();
        do_reset();
        step(4'b0001, 8'h00, "reset_first");
        step(4'b0001, 8'h01, "reset_hold");
        // assert reset between edges; outputs must clear with no clock
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt4 !== 4'b0000 || vld4 !== 1'b0 || idx4 !== 2'd0) begin
            errors++;
            $display("FAIL async_reset n=4: got gnt=%b vld=%b idx=%0d expected 0000/0/0", gnt4, vld4, idx4);
        end
        checks++;
        if (gnt8 !== 8'h00 || vld8 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset n=8: got gnt=%h vld=%b expected 00/0", gnt8, vld8);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        step(4'b0001, 8'h00, "after_reset");
        checks++;
        if (gnt4 !== 4'b0001) begin
            errors++;
            $display("FAIL after_reset_grant: got %b expected 0001", gnt4);
        end
    endtask

    task automatic test_rotation();
        int held;
        int prev;
        int seq[$];
        int exp_seq[5];
        logic [3:0] r;
        exp_seq = '{0, 1, 2, 3, 0};
        do_reset();
        held = 0;
        for (int c = 0; c < 40 && seq.size() < 5; c++) begin
            r = 4'hF;
            if (m_owner[0] >= 0 && held >= 3) r[m_owner[0]] = 1'b0;
            prev = m_owner[0];
            step(r, 8'h00, "rotation");
            if (m_owner[0] != prev) held = 1;
            else held++;
            if (new4 === 1'b1) seq.push_back(int'(idx4));
        end
        checks++;
        if (seq.size() != 5) begin
            errors++;
            $display("FAIL rotation_count: got %0d grants expected 5", seq.size());
        end
        for (int i = 0; i < 5 && i < seq.size(); i++) begin
            checks++;
            if (seq[i] != exp_seq[i]) begin
                errors++;
                $display("FAIL rotation_order[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_idle_ptr();
        do_reset();
        step(4'b0100, 8'h00, "idle_grant2");
        checks++;
        if (gnt4 !== 4'b0100) begin
            errors++;
            $display("FAIL idle_grant2: got %b expected 0100", gnt4);
        end
        step(4'b0000, 8'h00, "idle_release");
        checks++;
        if (gnt4 !== 4'b0000 || vld4 !== 1'b0) begin
            errors++;
            $display("FAIL idle_release: got gnt=%b vld=%b expected 0000/0", gnt4, vld4);
        end
        step(4'b1001, 8'h00, "idle_ptr_kept");
        checks++;
        if (gnt4 !== 4'b1000 || idx4 !== 2'd3) begin
            errors++;
            $display("FAIL idle_ptr_kept: got gnt=%b idx=%0d expected 1000/3", gnt4, idx4);
        end
    endtask

    task automatic test_hold_timeout();
        do_reset();
        step(4'b0001, 8'h00, "hold_start");
`ifdef RRA_TIMEOUT_EN
        begin
            int cnt;
            cnt = 1;
            for (int c = 0; c < 20; c++) begin
                step(4'b0101, 8'h00, "timeout");
                if (gnt4 === 4'b0001) cnt++;
                else break;
            end
            checks++;
            if (cnt != 4 || gnt4 !== 4'b0100 || to4 !== 1'b1) begin
                errors++;
                $display("FAIL timeout_rotate: got cycles=%0d gnt=%b evt=%b expected 4/0100/1", cnt, gnt4, to4);
            end
            step(4'b0101, 8'h00, "timeout_pulse");
            checks++;
            if (to4 !== 1'b0 || gnt4 !== 4'b0100) begin
                errors++;
                $display("FAIL timeout_pulse: got gnt=%b evt=%b expected 0100/0", gnt4, to4);
            end
        end
`else
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 100; c++) begin
                step(4'b0101, 8'h00, "no_timeout");
                if (gnt4 !== 4'b0001 || to4 !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL no_timeout_hold: got %0d bad cycles expected 0", bad);
            end
            step(4'b0100, 8'h00, "no_timeout_drop");
            checks++;
            if (gnt4 !== 4'b0100) begin
                errors++;
                $display("FAIL no_timeout_drop: got %b expected 0100", gnt4);
            end
        end
`endif
    endtask

    task automatic test_n8();
        do_reset();
        step(4'b0000, 8'h81, "n8_first");
        checks++;
        if (gnt8 !== 8'h01) begin
            errors++;
            $display("FAIL n8_first: got %h expected 01", gnt8);
        end
        step(4'b0000, 8'h80, "n8_handover");
        checks++;
        if (gnt8 !== 8'h80 || idx8 !== 3'd7) begin
            errors++;
            $display("FAIL n8_handover: got gnt=%h idx=%0d expected 80/7", gnt8, idx8);
        end
    endtask

    // Sticky random requests: a master raises req at random and keeps it
    // until it has held the bus for a random 1..6 cycles.
    task automatic test_random();
        bit want[2][8];
        int held[2];
        int dur[2];
        int waitc[2][8];
        int maxw[2];
        logic [7:0] r[2];
        bit g;
        do_reset();
        for (int u = 0; u < 2; u++) begin
            held[u] = 0;
            dur[u]  = 1;
            maxw[u] = 0;
            for (int i = 0; i < 8; i++) begin
                want[u][i]  = 1'b0;
                waitc[u][i] = 0;
            end
        end
        for (int c = 0; c < 800; c++) begin
            for (int u = 0; u < 2; u++) begin
                r[u] = 8'h00;
                for (int i = 0; i < nn(u); i++) begin
                    if (!want[u][i] && $urandom_range(3) == 0) want[u][i] = 1'b1;
                    if (m_owner[u] == i && held[u] >= dur[u]) want[u][i] = 1'b0;
                    r[u][i] = want[u][i];
                end
            end
            step(r[0][3:0], r[1], "random");
            for (int u = 0; u < 2; u++) begin
                if (m_new[u]) begin
                    held[u] = 1;
                    dur[u]  = int'($urandom_range(1, 6));
                end else begin
                    held[u]++;
                end
                for (int i = 0; i < nn(u); i++) begin
                    g = (u == 0) ? ((i < 4) ? gnt4[i] : 1'b0) : gnt8[i];
                    if (r[u][i] && !g) waitc[u][i]++;
                    else waitc[u][i] = 0;
                    if (waitc[u][i] > maxw[u]) maxw[u] = waitc[u][i];
                end
            end
        end
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (maxw[u] > nn(u) * 7) begin
                errors++;
                $display("FAIL starvation n=%0d: got max wait %0d expected <= %0d", nn(u), maxw[u], nn(u) * 7);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req4  = '0;
        req8  = '0;
        model_reset();
        test_reset();
        test_rotation();
        test_idle_ptr();
        test_hold_timeout();
        test_n8();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
